// File: rtl/switch_debounce_ctrl_pkg.sv
// Shared definitions for the DIP-switch debounce path: FSM encoding, default
// debounce length and the MMIO status-word layout consumed by memorio.
package switch_debounce_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_COUNT  = 2'd1,
        ST_COMMIT = 2'd2
    } dbc_state_e;

    localparam int unsigned STABLE_CYCLES_DEFAULT = 20000;

    localparam int unsigned STATUS_PENDING_BIT = 31;
    localparam int unsigned STATUS_MASK_MSB    = 15;
    localparam int unsigned STATUS_MASK_LSB    = 0;

    function automatic logic [31:0] pack_status(input logic pend, input logic [15:0] mask);
        logic [31:0] word;
        word = '0;
        word[STATUS_PENDING_BIT] = pend;
        word[STATUS_MASK_MSB:STATUS_MASK_LSB] = mask;
        return word;
    endfunction

endpackage

// File: rtl/switch_debounce_ctrl_sync2.sv
// Two-flop synchroniser bringing the asynchronous switch pins into the clk domain.
module switch_debounce_ctrl_sync2 #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             switrst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] s1_q;

    always_ff @(posedge clk or posedge switrst) begin
        if (switrst) begin
            s1_q <= '0;
            q    <= '0;
        end else begin
            s1_q <= d;
            q    <= s1_q;
        end
    end

endmodule

// File: rtl/switch_debounce_ctrl.sv
// Debounces the board DIP switches, commits stable patterns and tracks which bits
// changed since the CPU last read the status word.
module switch_debounce_ctrl
    import switch_debounce_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH         = 16,
    parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEFAULT,
    parameter int unsigned CNT_W         = 16
) (
    input  logic             clk,
    input  logic             switrst,
    input  logic [WIDTH-1:0] sw_raw,
    input  logic             ack,
    output logic [WIDTH-1:0] sw_stable,
    output logic             sw_changed,
    output logic             pending,
    output logic [WIDTH-1:0] change_mask,
    output logic             busy
);

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(STABLE_CYCLES - 1);

    logic [WIDTH-1:0] sync;
    logic [WIDTH-1:0] candidate_q;
    logic [CNT_W-1:0] cnt_q;
    dbc_state_e       state_q;

    switch_debounce_ctrl_sync2 #(
        .WIDTH(WIDTH)
    ) u_sync2 (
        .clk    (clk),
        .switrst(switrst),
        .d      (sw_raw),
        .q      (sync)
    );

    always_ff @(posedge clk or posedge switrst) begin
        if (switrst) begin
            state_q     <= ST_IDLE;
            candidate_q <= '0;
            cnt_q       <= '0;
            sw_stable   <= '0;
            change_mask <= '0;
            pending     <= 1'b0;
            sw_changed  <= 1'b0;
            busy        <= 1'b0;
        end else begin
            sw_changed <= 1'b0;
            if (ack) begin
                pending     <= 1'b0;
                change_mask <= '0;
            end
            unique case (state_q)
                ST_IDLE: begin
                    if (sync != sw_stable) begin
                        candidate_q <= sync;
                        cnt_q       <= '0;
                        state_q     <= ST_COUNT;
                        busy        <= 1'b1;
                    end
                end
                ST_COUNT: begin
                    if (sync == sw_stable) begin
                        state_q <= ST_IDLE;
                        busy    <= 1'b0;
                    end else if (sync != candidate_q) begin
                        candidate_q <= sync;
                        cnt_q       <= '0;
                    end else if (cnt_q == CntLast) begin
                        state_q <= ST_COMMIT;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_COMMIT: begin
                    // A same-cycle ack drops older history but never this commit.
                    sw_stable   <= candidate_q;
                    change_mask <= (ack ? '0 : change_mask) | (sw_stable ^ candidate_q);
                    pending     <= 1'b1;
                    sw_changed  <= 1'b1;
                    state_q     <= ST_IDLE;
                    busy        <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_switch_debounce_ctrl.sv
// Bench for switch_debounce_ctrl: run-length reference model feeding a commit scoreboard.
module tb_switch_debounce_ctrl;

    localparam int unsigned S = 4;

    logic        clk = 1'b0;
    logic        switrst;
    logic [15:0] sw_raw;
    logic        ack;
    logic [15:0] sw_stable;
    logic        sw_changed;
    logic        pending;
    logic [15:0] change_mask;
    logic        busy;

    switch_debounce_ctrl #(
        .WIDTH        (16),
        .STABLE_CYCLES(S),
        .CNT_W        (16)
    ) dut (
        .clk        (clk),
        .switrst    (switrst),
        .sw_raw     (sw_raw),
        .ack        (ack),
        .sw_stable  (sw_stable),
        .sw_changed (sw_changed),
        .pending    (pending),
        .change_mask(change_mask),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference model: the FSM sees raw delayed by two edges; a pattern commits on the edge
    // after it has been seen, differing from the committed value, on S+1 consecutive edges.
    typedef struct packed {
        logic [15:0] stable;
        logic [15:0] mask;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] m_d1, m_d2, m_seen, m_stable, m_mask, m_runval;
    int          m_run;
    logic        m_sched, m_pending, m_changed;

    always @(posedge clk or posedge switrst) begin
        if (switrst) begin
            m_d1 = '0; m_d2 = '0; m_stable = '0; m_mask = '0; m_runval = '0;
            m_run = 0; m_sched = 1'b0; m_pending = 1'b0; m_changed = 1'b0;
            exp_q.delete();
        end else begin
            m_seen = m_d2;
            m_d2   = m_d1;
            m_d1   = sw_raw;
            m_changed = 1'b0;
            if (m_sched) begin
                m_mask    = (ack ? 16'h0 : m_mask) | (m_stable ^ m_runval);
                m_stable  = m_runval;
                m_pending = 1'b1;
                m_changed = 1'b1;
                m_sched   = 1'b0;
                m_run     = 0;
                exp_q.push_back({m_stable, m_mask});
            end else begin
                if (ack) begin
                    m_mask    = '0;
                    m_pending = 1'b0;
                end
                if (m_seen == m_stable) m_run = 0;
                else if (m_run > 0 && m_seen == m_runval) m_run++;
                else begin
                    m_runval = m_seen;
                    m_run    = 1;
                end
                if (m_run == S + 1) m_sched = 1'b1;
            end
        end
    end

    // Monitor: pops the scoreboard on every commit pulse and tracks steady-state outputs.
    exp_t mon_e;
    always @(negedge clk) begin
        if (!switrst) begin
            chk("cycle_outputs", {sw_stable, change_mask, pending, busy, sw_changed},
                {m_stable, m_mask, m_pending, (m_run > 0) || m_sched, m_changed});
            if (sw_changed) begin
                chk("commit_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    chk("commit_value", sw_stable, mon_e.stable);
                    chk("commit_mask", change_mask, mon_e.mask);
                    chk("commit_pending", pending, 1);
                end
            end
        end
    end

    task automatic wait_commit(input string name, input int max_cyc);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < max_cyc && !seen; i++) begin
            @(negedge clk);
            if (sw_changed) seen = 1'b1;
        end
        chk(name, seen, 1);
    endtask

    bit glitch_busy;
    bit ack_hit;
    int hold;

    initial begin
        switrst = 1'b1;
        ack     = 1'b0;
        sw_raw  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1 switrst = 1'b0;
        #1;
        chk("rst_stable", sw_stable, 0);
        chk("rst_pending", pending, 0);
        chk("rst_mask", change_mask, 0);
        chk("rst_busy", busy, 0);
        chk("rst_changed", sw_changed, 0);

        repeat (50) @(negedge clk);
        chk("idle_stable", sw_stable, 0);
        chk("idle_pending", pending, 0);
        chk("idle_busy", busy, 0);

        // Short glitch from zero never commits.
        sw_raw = 16'h0001;
        repeat (2) @(negedge clk);
        sw_raw = 16'h0000;
        glitch_busy = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (busy) glitch_busy = 1'b1;
        end
        chk("glitch_busy_seen", glitch_busy, 1);
        chk("glitch_stable", sw_stable, 0);
        chk("glitch_pending", pending, 0);

        // 0 -> 00A5 commits on the eighth edge.
        sw_raw = 16'h00A5;
        repeat (7) @(posedge clk);
        #1 chk("a5_before_e8", sw_stable, 16'h0000);
        @(posedge clk);
        #1;
        chk("a5_at_e8", sw_stable, 16'h00A5);
        chk("a5_changed", sw_changed, 1);
        chk("a5_pending", pending, 1);
        chk("a5_mask", change_mask, 16'h00A5);
        @(posedge clk);
        #1 chk("a5_pulse_single", sw_changed, 0);
        @(negedge clk);

        // Candidate replaced mid-count; mask accumulates without ack.
        sw_raw = 16'h00A4;
        repeat (2) @(negedge clk);
        sw_raw = 16'h80A4;
        wait_commit("commit_80a4_seen", 30);
        chk("restart_stable", sw_stable, 16'h80A4);
        chk("restart_mask", change_mask, 16'h80A5);
        repeat (10) @(negedge clk);

        // ack landing in the COMMIT cycle.
        sw_raw = 16'h0000;
        wait_commit("commit_zero_seen", 30);
        @(negedge clk);
        sw_raw  = 16'hFFFF;
        ack_hit = 1'b0;
        for (int i = 0; i < 30 && !ack_hit; i++) begin
            @(negedge clk);
            if (m_sched) begin
                ack     = 1'b1;
                ack_hit = 1'b1;
            end
        end
        chk("ack_commit_cycle_found", ack_hit, 1);
        @(negedge clk);
        ack = 1'b0;
        chk("ack_commit_pending", pending, 1);
        chk("ack_commit_mask", change_mask, 16'hFFFF);
        chk("ack_commit_stable", sw_stable, 16'hFFFF);
        repeat (3) @(negedge clk);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        chk("lone_ack_pending", pending, 0);
        chk("lone_ack_mask", change_mask, 0);

        // Asynchronous reset in the middle of COUNT.
        sw_raw = 16'h5A5A;
        repeat (4) @(negedge clk);
        chk("mid_count_busy", busy, 1);
        #2 switrst = 1'b1;
        #1;
        chk("async_rst_stable", sw_stable, 0);
        chk("async_rst_pending", pending, 0);
        chk("async_rst_mask", change_mask, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_changed", sw_changed, 0);
        @(negedge clk);
        #1 switrst = 1'b0;
        repeat (S + 3) @(posedge clk);
        #1 chk("redebounce_before", sw_stable, 16'h0000);
        @(posedge clk);
        #1;
        chk("redebounce_stable", sw_stable, 16'h5A5A);
        chk("redebounce_changed", sw_changed, 1);
        @(negedge clk);

        // Randomised traffic against the model.
        for (int it = 0; it < 250; it++) begin
            hold = int'($urandom_range(1, 7));
            case ($urandom_range(0, 3))
                0:       sw_raw = sw_raw ^ 16'(1 << $urandom_range(0, 15));
                1:       sw_raw = 16'($urandom);
                2:       sw_raw = m_stable;
                default: sw_raw = sw_raw;
            endcase
            for (int c = 0; c < hold; c++) begin
                ack = ($urandom_range(0, 7) == 0);
                @(negedge clk);
            end
        end
        ack = 1'b0;
        repeat (20) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: run exceeded time limit, got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/switch_debounce_ctrl.md
Name: switch_debounce_ctrl

Overview:
- Sequences the 16 board DIP switches into the switch read path: synchronises, debounces and commits raw switch levels.
- Tracks which bits changed since the CPU last acknowledged.
- sw_stable drives the switch peripheral's read-data input. pending/change_mask go to the MMIO status word; ack is the MMIO status-read strobe from memorio.
- Single clock domain (CPU clock, posedge).

Parameters:
- WIDTH, 16, number of switch bits.
- STABLE_CYCLES, 20000, consecutive cycles a new pattern must hold before commit; legal range 2..2^CNT_W.
- CNT_W, 16, stability counter width.

Ports:
- clk  input  1  system clock, posedge.
- switrst  input  1  reset; asynchronous, active-high.
- sw_raw  input  WIDTH  raw switch pins, asynchronous to clk.
- ack  input  1  one-cycle strobe: CPU read the status word; clears pending and change_mask.
- sw_stable  output  WIDTH  debounced switch pattern.
- sw_changed  output  1  one-cycle pulse on every commit.
- pending  output  1  at least one commit since the last ack.
- change_mask  output  WIDTH  OR-accumulated bits that toggled since the last ack.
- busy  output  1  high while the FSM is not IDLE.

Behaviour:
- Reset (async, any cycle, including mid-COUNT):
  - sync flops, candidate, cnt, sw_stable, change_mask = 0.
  - pending = 0, sw_changed = 0, state = IDLE.
  - Switches already on at reset commit STABLE_CYCLES+4 edges after reset release.
- Synchroniser: two-flop chain sw_raw -> s1 -> sync. The FSM only ever sees sync.
- FSM states IDLE, COUNT, COMMIT (2-bit encoding):
  - IDLE: if sync != sw_stable then candidate <= sync, cnt <= 0, go COUNT. Otherwise stay.
  - COUNT, first matching rule wins:
    - (a) sync == sw_stable: glitch returned to committed value; go IDLE, no commit.
    - (b) sync != candidate: new pattern; candidate <= sync, cnt <= 0, stay in COUNT.
    - (c) cnt == STABLE_CYCLES-1: go COMMIT.
    - (d) otherwise cnt <= cnt+1.
  - COMMIT: sw_stable <= candidate, change_mask <= change_mask | (sw_stable ^ candidate), pending <= 1, sw_changed <= 1 for exactly the next cycle, go IDLE.
- Latency:
  - Raw change settled before sampling edge E1: sync updates at E2; COUNT entered at E3; COMMIT entered at E(STABLE_CYCLES+3); sw_stable updates at E(STABLE_CYCLES+4).
  - sw_changed is high in the cycle following that edge.
- ack alone: pending <= 0, change_mask <= 0 on the next edge.
- ack in the same cycle as COMMIT: the commit wins. pending stays 1 and change_mask = only the bits toggled by this commit; older bits are discarded.
- Repeated commits without ack: change_mask accumulates by OR and pending stays 1; no overflow condition.
- cnt never exceeds STABLE_CYCLES-1 and never wraps.
- busy = (state != IDLE).
- All outputs registered; no combinational path from sw_raw or ack to any output.

Decomposition:
- Shared package holds:
  - the FSM state encoding (ST_IDLE=2'd0, ST_COUNT=2'd1, ST_COMMIT=2'd2);
  - the default STABLE_CYCLES constant;
  - the MMIO status-word layout (bit 31 = pending, bits 15:0 = change_mask), used by memorio.
- One natural sub-module: sync2, a two-flop synchroniser, WIDTH-parameterised, reset by switrst.
- FSM, counter and mask logic stay in the top module.

Test Plan (STABLE_CYCLES=4):
- Reset release with sw_raw=16'h0000 held -> sw_stable=0, pending=0, busy=0 for 50 cycles; sw_changed never pulses.
- sw_raw 0 -> 16'h00A5 at E1, held -> sw_stable=16'h00A5 at E8; sw_changed single pulse; pending=1; change_mask=16'h00A5.
- sw_raw=16'h0001 for 2 cycles, then back to 0 (starting from 0) -> no commit; busy pulses; sw_stable stays 0; pending stays 0.
- From 16'h00A5: raw -> 16'h00A4 held 2 cycles, then -> 16'h80A4 held -> counter restarts; commit 16'h80A4 only; change_mask = 16'h80A5 (accumulated, no ack).
- ack asserted in exactly the COMMIT cycle of 16'h0000 -> 16'hFFFF -> next cycle pending=1, change_mask=16'hFFFF; a later lone ack -> pending=0, change_mask=0.
- switrst pulsed mid-COUNT -> all outputs 0 immediately (async, before the next clock edge); FSM in IDLE; re-debounce of the held value completes STABLE_CYCLES+4 edges after release.
